block_padding_mp: RTL and testbench

- Parametrised successor of the store-side row-padding mask generator. It sits between the genpu_ctrl store config path and the ldst_ddr store address/data streams.
- It flags, per beat, which store address and data beats fall into padded rows of an output plane. Padded rows can be top and/or bottom, so garbage rows are never written to DDR.
- It generalises the two-part (up/down) scheme to NUM_PARTS interleaved image parts with a per-part block mask.
- It supports a parametrised st0/st1 interleave pattern, a configurable st1 size ratio and a configurable upsample address multiplier.

---
 rtl/block_padding_mp.sv | 233 +++++++++++++++++++++++
 tb/tb_block_padding_mp.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/block_padding_mp.sv
// Store-side padding mask: flags store address/data beats that fall into padded
// rows of an output plane, for NUM_PARTS interleaved parts and an optional st1 plane.
module block_padding_mp #(
  parameter int IMM_WIDTH     = 16,
  parameter int LOOP_ITER_W   = 16,
  parameter int NUM_PARTS     = 2,
  parameter int ILV_PERIOD    = 10,
  parameter int ILV_ST0_SLOTS = 2,
  parameter int ST1_RATIO     = 4,
  parameter int UPS_MULT      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_pad_v,
  input  logic [IMM_WIDTH-1:0]   cfg_rows_top,
  input  logic [IMM_WIDTH-1:0]   cfg_rows_bot,
  input  logic [NUM_PARTS-1:0]   cfg_part_mask,
  input  logic                   cfg_loop_iter_st_v,
  input  logic                   cfg_loop_iter_st1_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter_st,
  input  logic                   upsample_required,
  input  logic                   flush,
  input  logic                   addr_valid,
  input  logic                   data_valid,
  output logic                   cfg_ready,
  output logic                   block_required,
  output logic                   addr_block,
  output logic                   data_block,
  output logic                   all_done
);
  localparam int TW        = 2*LOOP_ITER_W + 4;
  localparam int DW        = LOOP_ITER_W + 1;
  localparam int OW        = LOOP_ITER_W + 1;
  localparam int SW        = (ILV_PERIOD > 1) ? $clog2(ILV_PERIOD) : 1;
  localparam int PW        = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1;
  localparam int ST0_FIRST = ILV_PERIOD - ILV_ST0_SLOTS;
  localparam int ADDR      = 0;
  localparam int DATA      = 1;

  typedef enum logic [3:0] {
    S_PART, S_UPR, S_UPL, S_W, S_H, S_OC, S_B, S_CALC, S_RUN
  } state_t;

  state_t state, state_nxt;

  logic [IMM_WIDTH-1:0]   top_r, bot_r;
  logic [NUM_PARTS-1:0]   mask_r;
  logic                   st1_exist;
  logic                   ups_r;
  logic [DW-1:0]          w_r, h_r;
  logic [LOOP_ITER_W-1:0] ocmax_r;
  logic                   ld_ups, ld_w, ld_h, ld_oc;

  // Product truncated to the threshold width.
  function automatic logic [TW-1:0] scale(input logic [TW-1:0] v, input int unsigned m);
    return v * TW'(m);
  endfunction

  function automatic int unsigned stream_mult(input int s, input logic ups);
    if (s == ADDR && ups) return NUM_PARTS * UPS_MULT;
    return NUM_PARTS;
  endfunction

  // ---------------- config capture FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= S_PART;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ups    = 1'b0;
    ld_w      = 1'b0;
    ld_h      = 1'b0;
    ld_oc     = 1'b0;
    unique case (state)
      S_PART, S_RUN: if (cfg_loop_iter_st_v) begin
        ld_ups    = 1'b1;
        state_nxt = upsample_required ? S_UPR : S_W;
      end
      S_UPR: if (cfg_loop_iter_st_v) state_nxt = S_UPL;
      S_UPL: if (cfg_loop_iter_st_v) state_nxt = S_W;
      S_W: if (cfg_loop_iter_st_v) begin
        ld_w      = 1'b1;
        state_nxt = S_H;
      end
      S_H: if (cfg_loop_iter_st_v) begin
        ld_h      = 1'b1;
        state_nxt = S_OC;
      end
      S_OC: if (cfg_loop_iter_st_v) begin
        ld_oc     = 1'b1;
        state_nxt = S_B;
      end
      S_B:    if (cfg_loop_iter_st_v) state_nxt = S_CALC;
      S_CALC: state_nxt = S_RUN;
      default: state_nxt = S_PART;
    endcase
    if (cfg_pad_v) begin
      state_nxt = S_PART;
      ld_ups    = 1'b0;
      ld_w      = 1'b0;
      ld_h      = 1'b0;
      ld_oc     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      top_r  <= '0;
      bot_r  <= '0;
      mask_r <= '0;
    end else if (cfg_pad_v) begin
      top_r  <= cfg_rows_top;
      bot_r  <= cfg_rows_bot;
      mask_r <= cfg_part_mask;
    end
  end

  // A st0 loop-iter beat means the layer has no st1 unless st1_v follows.
  always_ff @(posedge clk) begin
    if (reset)                    st1_exist <= 1'b0;
    else if (cfg_loop_iter_st_v)  st1_exist <= 1'b0;
    else if (cfg_loop_iter_st1_v) st1_exist <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (ld_ups) ups_r   <= upsample_required;
    if (ld_w)   w_r     <= DW'(cfg_loop_iter_st) + DW'(1);
    if (ld_h)   h_r     <= DW'(cfg_loop_iter_st) + DW'(1);
    if (ld_oc)  ocmax_r <= cfg_loop_iter_st;
  end

  // ---------------- thresholds, registered in S_CALC ----------------
  logic [TW-1:0] w_t, h_t, top_t, bot_t;
  logic [TW-1:0] base_f, base_t, base_b;
  logic          clamp;
  logic [TW-1:0] f_nxt [2][2];
  logic [TW-1:0] t_nxt [2][2];
  logic [TW-1:0] b_nxt [2][2];
  logic [TW-1:0] f_thr [2][2];
  logic [TW-1:0] t_thr [2][2];
  logic [TW-1:0] b_thr [2][2];

  always_comb begin
    w_t    = TW'(w_r);
    h_t    = TW'(h_r);
    top_t  = TW'(top_r);
    bot_t  = TW'(bot_r);
    clamp  = (top_t + bot_t) >= h_t;
    base_f = w_t * h_t;
    base_t = w_t * top_t;
    base_b = clamp ? base_t : w_t * (h_t - bot_t);
    for (int s = 0; s < 2; s++) begin
      f_nxt[s][0] = scale(base_f, stream_mult(s, ups_r));
      t_nxt[s][0] = scale(base_t, stream_mult(s, ups_r));
      b_nxt[s][0] = scale(base_b, stream_mult(s, ups_r));
      f_nxt[s][1] = scale(f_nxt[s][0], ST1_RATIO);
      t_nxt[s][1] = scale(t_nxt[s][0], ST1_RATIO);
      b_nxt[s][1] = scale(b_nxt[s][0], ST1_RATIO);
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_CALC) begin
      for (int s = 0; s < 2; s++) begin
        for (int p = 0; p < 2; p++) begin
          f_thr[s][p] <= f_nxt[s][p];
          t_thr[s][p] <= t_nxt[s][p];
          b_thr[s][p] <= b_nxt[s][p];
        end
      end
    end
  end

  // ---------------- per-stream beat tracking ----------------
  logic [1:0]    beat_v;
  logic [SW-1:0] slot   [2];
  logic [TW-1:0] k_cnt  [2][2];
  logic [OW-1:0] oc_cnt [2];
  logic          sub_sel [2];
  logic [TW-1:0] k_cur   [2];
  logic          wrap    [2];
  logic          blk     [2];
  logic          done;

  assign beat_v    = {data_valid, addr_valid};
  assign cfg_ready = (state == S_RUN);
  assign done      = cfg_ready && (oc_cnt[DATA] > OW'(ocmax_r));

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      sub_sel[s] = st1_exist && (slot[s] < SW'(ST0_FIRST));
      k_cur[s]   = k_cnt[s][sub_sel[s]];
      wrap[s]    = (k_cur[s] == f_thr[s][sub_sel[s]] - TW'(1));
      blk[s]     = beat_v[s] && cfg_ready && block_required && !done
                   && ((k_cur[s] < t_thr[s][sub_sel[s]]) || (k_cur[s] >= b_thr[s][sub_sel[s]]))
                   && mask_r[PW'(k_cur[s] % TW'(NUM_PARTS))]
                   && (oc_cnt[s] <= OW'(ocmax_r));
    end
  end

  // Flush and config both discard the beat in flight; its flag uses the old state.
  always_ff @(posedge clk) begin
    if (reset || cfg_pad_v || flush) begin
      for (int s = 0; s < 2; s++) begin
        slot[s]     <= '0;
        oc_cnt[s]   <= '0;
        k_cnt[s][0] <= '0;
        k_cnt[s][1] <= '0;
      end
    end else if (cfg_ready) begin
      for (int s = 0; s < 2; s++) begin
        if (beat_v[s]) begin
          if (st1_exist)
            slot[s] <= (slot[s] == SW'(ILV_PERIOD - 1)) ? '0 : slot[s] + SW'(1);
          if (wrap[s]) begin
            k_cnt[s][sub_sel[s]] <= '0;
            if (!sub_sel[s] && (oc_cnt[s] != '1)) oc_cnt[s] <= oc_cnt[s] + OW'(1);
          end else begin
            k_cnt[s][sub_sel[s]] <= k_cur[s] + TW'(1);
          end
        end
      end
    end
  end

  assign block_required = (top_r != '0) || (bot_r != '0);
  assign addr_block     = blk[ADDR];
  assign data_block     = blk[DATA];
  assign all_done       = done;

endmodule

// File: tb/tb_block_padding_mp.sv
// Self-checking bench for block_padding_mp: table of padding configs plus
// hand-written st1, flush, reconfig and reset sequences.
module tb_block_padding_mp;
  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_pad_v;
  logic [15:0] cfg_rows_top, cfg_rows_bot;
  logic [1:0]  cfg_part_mask;
  logic        cfg_loop_iter_st_v, cfg_loop_iter_st1_v;
  logic [15:0] cfg_loop_iter_st;
  logic        upsample_required, flush, addr_valid, data_valid;
  logic        cfg_ready, block_required, addr_block, data_block, all_done;

  block_padding_mp dut (
    .clk(clk), .reset(reset), .cfg_pad_v(cfg_pad_v),
    .cfg_rows_top(cfg_rows_top), .cfg_rows_bot(cfg_rows_bot),
    .cfg_part_mask(cfg_part_mask), .cfg_loop_iter_st_v(cfg_loop_iter_st_v),
    .cfg_loop_iter_st1_v(cfg_loop_iter_st1_v), .cfg_loop_iter_st(cfg_loop_iter_st),
    .upsample_required(upsample_required), .flush(flush),
    .addr_valid(addr_valid), .data_valid(data_valid),
    .cfg_ready(cfg_ready), .block_required(block_required),
    .addr_block(addr_block), .data_block(data_block), .all_done(all_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       top, bot;
    bit [1:0] mask;
    bit       ups;
    int       wv, hv, ocv;
    bit       req;
    int       fa, ta, ba, fd, td, bd;
  } row_t;

  row_t rows[6];
  int   checks = 0;
  int   errors = 0;
  bit   exp_a_q[$];
  bit   exp_d_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat: expectations queued on drive, popped when outputs are sampled.
  task automatic beat(input bit a, input bit d, input bit ea, input bit ed, input string nm);
    addr_valid = a;
    data_valid = d;
    exp_a_q.push_back(ea);
    exp_d_q.push_back(ed);
    @(negedge clk);
    check({nm, "_addr"}, addr_block, exp_a_q.pop_front());
    check({nm, "_data"}, data_block, exp_d_q.pop_front());
    step();
    addr_valid = 1'b0;
    data_valid = 1'b0;
  endtask

  task automatic cfg_pad(input int top, input int bot, input bit [1:0] mask);
    cfg_pad_v     = 1'b1;
    cfg_rows_top  = 16'(top);
    cfg_rows_bot  = 16'(bot);
    cfg_part_mask = mask;
    step();
    cfg_pad_v = 1'b0;
  endtask

  task automatic send_st(input int v);
    cfg_loop_iter_st_v = 1'b1;
    cfg_loop_iter_st   = 16'(v);
    step();
    cfg_loop_iter_st_v = 1'b0;
  endtask

  task automatic cfg_seq(input bit ups, input bit st1, input int wv, input int hv,
                         input int ocv, input string nm);
    upsample_required = ups;
    send_st(0);
    upsample_required = 1'b0;
    if (ups) begin
      send_st(0);
      send_st(0);
    end
    send_st(wv);
    send_st(hv);
    send_st(ocv);
    send_st(0);
    if (st1) cfg_loop_iter_st1_v = 1'b1;
    check({nm, "_ready_calc"}, cfg_ready, 0);
    step();
    cfg_loop_iter_st1_v = 1'b0;
    check({nm, "_ready_run"}, cfg_ready, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cfg_pad_v = 1'b0; cfg_rows_top = '0; cfg_rows_bot = '0;
    cfg_part_mask = '0; cfg_loop_iter_st_v = 1'b0; cfg_loop_iter_st1_v = 1'b0;
    cfg_loop_iter_st = '0; upsample_required = 1'b0; flush = 1'b0;
    addr_valid = 1'b0; data_valid = 1'b0;

    //         top bot mask  ups wv hv oc req  fa  ta  ba   fd ta  bd
    rows[0] = '{0, 1, 2'b10, 0, 3, 3, 0, 1,  32,  0, 24,  32,  0, 24};
    rows[1] = '{1, 0, 2'b11, 0, 3, 3, 0, 1,  32,  8, 32,  32,  8, 32};
    rows[2] = '{0, 0, 2'b11, 0, 3, 3, 0, 0,  32,  0, 32,  32,  0, 32};
    rows[3] = '{0, 1, 2'b10, 1, 3, 3, 1, 1, 128,  0, 96,  32,  0, 24};
    rows[4] = '{3, 2, 2'b01, 0, 3, 3, 0, 1,  32, 24, 24,  32, 24, 24};
    rows[5] = '{1, 2, 2'b11, 0, 2, 4, 0, 1,  30,  6, 18,  30,  6, 18};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_cfg_ready", cfg_ready, 0);
    check("rst_block_required", block_required, 0);
    check("rst_all_done", all_done, 0);
    beat(1, 1, 0, 0, "rst_beat");

    for (int r = 0; r < 6; r++) begin
      row_t t;
      int   an, dn, nmax;
      string nm;
      t  = rows[r];
      nm = $sformatf("row%0d", r);
      cfg_pad(t.top, t.bot, t.mask);
      check({nm, "_block_required"}, block_required, t.req);
      cfg_seq(t.ups, 1'b0, t.wv, t.hv, t.ocv, nm);
      check({nm, "_done_start"}, all_done, 0);
      an   = t.fa * (t.ocv + 1);
      dn   = t.fd * (t.ocv + 1);
      nmax = (an > dn) ? an : dn;
      for (int i = 0; i < nmax; i++) begin
        int ia, id, ka, kd;
        bit va, vd, ea, ed;
        ia = i - (nmax - an);
        id = i - (nmax - dn);
        va = (ia >= 0);
        vd = (id >= 0);
        ea = 1'b0;
        ed = 1'b0;
        if (va) begin
          ka = ia % t.fa;
          ea = t.req && ((ka < t.ta) || (ka >= t.ba)) && t.mask[ka % 2];
        end
        if (vd) begin
          kd = id % t.fd;
          ed = t.req && ((kd < t.td) || (kd >= t.bd)) && t.mask[kd % 2];
        end
        if (i == nmax - 1) check({nm, "_done_before_last"}, all_done, 0);
        beat(va, vd, ea, ed, $sformatf("%s_b%0d", nm, i));
      end
      check({nm, "_done_end"}, all_done, 1);
      beat(1, 1, 0, 0, {nm, "_after_done"});
    end

    // st1 interleave: slots 8,9 are st0 (F=32,B=24), others st1 (F=128,B=96).
    begin
      int slot, k0, k1;
      cfg_pad(0, 1, 2'b10);
      cfg_seq(1'b0, 1'b1, 3, 3, 0, "st1");
      slot = 0; k0 = 0; k1 = 0;
      for (int i = 0; i < 160; i++) begin
        bit st0, e;
        int k, f, b;
        st0 = (slot >= 8);
        k   = st0 ? k0 : k1;
        f   = st0 ? 32 : 128;
        b   = st0 ? 24 : 96;
        e   = (k >= b) && (k % 2 == 1);
        beat(1, 1, e, e, $sformatf("st1_b%0d", i));
        if (st0) k0 = (k == f - 1) ? 0 : k + 1;
        else     k1 = (k == f - 1) ? 0 : k + 1;
        slot = (slot == 9) ? 0 : slot + 1;
      end
      check("st1_done_end", all_done, 1);
    end

    // Flush at k=13 with a concurrent beat; Td=16 with mask 11.
    cfg_pad(2, 0, 2'b11);
    cfg_seq(1'b0, 1'b0, 3, 3, 0, "fl");
    for (int i = 0; i < 13; i++) beat(1, 1, 1, 1, $sformatf("fl_pre%0d", i));
    flush = 1'b1;
    beat(1, 1, 1, 1, "fl_flush_beat");
    flush = 1'b0;
    for (int i = 0; i < 16; i++) beat(1, 1, 1, 1, $sformatf("fl_post%0d", i));
    beat(1, 1, 0, 0, "fl_k16");

    // Config strobe together with a beat at k=17: beat flagged from old state.
    cfg_pad_v = 1'b1; cfg_rows_top = 16'd1; cfg_rows_bot = 16'd0; cfg_part_mask = 2'b11;
    beat(1, 1, 0, 0, "pad_beat");
    cfg_pad_v = 1'b0;
    check("pad_cfg_ready", cfg_ready, 0);
    beat(1, 1, 0, 0, "spart_beat");
    check("spart_cfg_ready", cfg_ready, 0);
    cfg_seq(1'b0, 1'b0, 3, 3, 0, "re");
    for (int i = 0; i < 9; i++) beat(1, 1, i < 8, i < 8, $sformatf("re_k%0d", i));

    // st_v while running restarts capture.
    cfg_loop_iter_st_v = 1'b1;
    cfg_loop_iter_st   = 16'd0;
    check("restart_ready_before", cfg_ready, 1);
    step();
    cfg_loop_iter_st_v = 1'b0;
    check("restart_ready_after", cfg_ready, 0);

    // Reset mid-plane with valid beats held high.
    cfg_pad(1, 0, 2'b11);
    cfg_seq(1'b0, 1'b0, 3, 3, 0, "rs");
    for (int i = 0; i < 5; i++) beat(1, 1, 1, 1, $sformatf("rs_pre%0d", i));
    reset = 1'b1; addr_valid = 1'b1; data_valid = 1'b1;
    step();
    check("rs_cfg_ready", cfg_ready, 0);
    check("rs_block_required", block_required, 0);
    check("rs_all_done", all_done, 0);
    @(negedge clk);
    check("rs_addr_block", addr_block, 0);
    check("rs_data_block", data_block, 0);
    step();
    reset = 1'b0; addr_valid = 1'b0; data_valid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
